// File: rtl/jtframe_romrq_pkg.sv
// Shared definitions for the ROM-request arbiter slice.
//   SDRAM_AW / SDRAM_DW : SDRAM word-address and data widths
//   romrq_st_e          : arbiter transaction state
package jtframe_romrq_pkg;
  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned SDRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } romrq_st_e;
endpackage

// File: rtl/jtframe_rr_arb.sv
// Combinational rotating-priority encoder.
//   req : per-requester request level
//   ptr : index where the search starts (ignored when RR=0)
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : binary index of the granted requester
//   any : at least one requester is pending
module jtframe_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned RR = 1,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int unsigned base;
  int unsigned j;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    base = (RR != 0) ? 32'(ptr) : 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (base + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/jtframe_romrq_arb.sv
// Arbiter between SLOTS ROM request clients and one SDRAM read port.
//   rst, clk    : async active-high reset, clock
//   slot_req    : per-slot request level
//   slot_addr   : per-slot word address, slot i at [22*i+21:22*i]
//   slot_we     : one-hot owner of the current transaction
//   din, din_ok : read data broadcast and its one-cycle strobe
//   sdram_req/sdram_addr/sdram_ack/sdram_rdy/sdram_dout : SDRAM read port
//   busy        : arbiter not idle
module jtframe_romrq_arb
  import jtframe_romrq_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned RR    = 1
) (
  input  logic                        rst,
  input  logic                        clk,
  input  logic [SLOTS-1:0]            slot_req,
  input  logic [SLOTS*SDRAM_AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]            slot_we,
  output logic [SDRAM_DW-1:0]         din,
  output logic                        din_ok,
  output logic                        sdram_req,
  output logic [SDRAM_AW-1:0]         sdram_addr,
  input  logic                        sdram_ack,
  input  logic                        sdram_rdy,
  input  logic [SDRAM_DW-1:0]         sdram_dout,
  output logic                        busy
);
  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  romrq_st_e             st, st_n;
  logic [IW-1:0]         ptr, ptr_n;
  logic [SLOTS-1:0]      we_n;
  logic [SDRAM_DW-1:0]   din_n;
  logic                  din_ok_n, req_n;
  logic [SDRAM_AW-1:0]   addr_n, gnt_addr;
  logic [SLOTS-1:0]      gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;

  jtframe_rr_arb #(.N(SLOTS), .RR(RR), .IW(IW)) u_arb (
    .req (slot_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    gnt_addr = '0;
    for (int unsigned i = 0; i < SLOTS; i++)
      if (gnt[i]) gnt_addr = slot_addr[i*SDRAM_AW +: SDRAM_AW];
  end

  always_comb begin
    st_n     = st;
    ptr_n    = ptr;
    we_n     = slot_we;
    din_n    = din;
    din_ok_n = 1'b0;
    req_n    = sdram_req;
    addr_n   = sdram_addr;
    unique case (st)
      ST_IDLE: begin
        // slot_we survives the din_ok cycle and is replaced or cleared here
        we_n = '0;
        if (gnt_any) begin
          we_n   = gnt;
          addr_n = gnt_addr;
          req_n  = 1'b1;
          st_n   = ST_REQ;
          if (RR != 0)
            ptr_n = (gnt_idx == IW'(SLOTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_n = 1'b0;
          // rdy together with ack completes the read without visiting WAIT
          if (sdram_rdy) begin
            din_n    = sdram_dout;
            din_ok_n = 1'b1;
            st_n     = ST_IDLE;
          end else begin
            st_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram_rdy) begin
          din_n    = sdram_dout;
          din_ok_n = 1'b1;
          st_n     = ST_IDLE;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      ptr        <= '0;
      slot_we    <= '0;
      din        <= '0;
      din_ok     <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      busy       <= 1'b0;
    end else begin
      st         <= st_n;
      ptr        <= ptr_n;
      slot_we    <= we_n;
      din        <= din_n;
      din_ok     <= din_ok_n;
      sdram_req  <= req_n;
      sdram_addr <= addr_n;
      busy       <= (st_n != ST_IDLE);
    end
  end
endmodule

// File: tb/tb_jtframe_romrq_arb.sv
module tb_jtframe_romrq_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_rr, req_fp;
  logic [87:0] slot_addr;
  logic        ack, rdy;
  logic [31:0] dout;

  logic [3:0]  r_we, f_we;
  logic [31:0] r_din, f_din;
  logic        r_ok, f_ok, r_req, f_req, r_busy, f_busy;
  logic [21:0] r_addr, f_addr;

  int total = 0;
  int bad   = 0;
  logic [35:0] q_rr[$];
  logic [35:0] q_fp[$];

  always #5 clk = ~clk;

  jtframe_romrq_arb #(.SLOTS(4), .RR(1)) dut_rr (
    .rst(rst), .clk(clk), .slot_req(req_rr), .slot_addr(slot_addr),
    .slot_we(r_we), .din(r_din), .din_ok(r_ok), .sdram_req(r_req),
    .sdram_addr(r_addr), .sdram_ack(ack), .sdram_rdy(rdy),
    .sdram_dout(dout), .busy(r_busy));

  jtframe_romrq_arb #(.SLOTS(4), .RR(0)) dut_fp (
    .rst(rst), .clk(clk), .slot_req(req_fp), .slot_addr(slot_addr),
    .slot_we(f_we), .din(f_din), .din_ok(f_ok), .sdram_req(f_req),
    .sdram_addr(f_addr), .sdram_ack(ack), .sdram_rdy(rdy),
    .sdram_dout(dout), .busy(f_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every din_ok must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && r_ok) begin
      total++;
      if (q_rr.size() == 0) begin
        bad++;
        $display("FAIL rr_din_ok: got we=%b din=%h expected no strobe", r_we, r_din);
      end else begin
        logic [35:0] e;
        e = q_rr.pop_front();
        if ({r_we, r_din} !== e) begin
          bad++;
          $display("FAIL rr_din_ok: got we=%b din=%h expected we=%b din=%h",
                   r_we, r_din, e[35:32], e[31:0]);
        end
      end
    end
    if (!rst && f_ok) begin
      total++;
      if (q_fp.size() == 0) begin
        bad++;
        $display("FAIL fp_din_ok: got we=%b din=%h expected no strobe", f_we, f_din);
      end else begin
        logic [35:0] e;
        e = q_fp.pop_front();
        if ({f_we, f_din} !== e) begin
          bad++;
          $display("FAIL fp_din_ok: got we=%b din=%h expected we=%b din=%h",
                   f_we, f_din, e[35:32], e[31:0]);
        end
      end
    end
    if (!rst && r_we != 4'd0 && !$onehot(r_we)) begin
      total++; bad++;
      $display("FAIL rr_onehot: got we=%b expected one-hot", r_we);
    end
  end

  // Acts as the SDRAM controller for one transaction on the selected DUT.
  task automatic serve(input bit fp, input int ack_dly, input int rdy_dly,
                       input logic [31:0] data, input logic [21:0] exp_addr,
                       input logic [3:0] exp_we, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (fp ? f_req : r_req) seen = 1'b1;
    end
    if (!seen) begin
      chk("grant_timeout", 64'd0, 64'd1);
      return;
    end
    chk("grant_addr", 64'(fp ? f_addr : r_addr), 64'(exp_addr));
    chk("grant_we",   64'(fp ? f_we : r_we),     64'(exp_we));
    if (drop) begin
      if (fp) req_fp = '0; else req_rr = '0;
    end
    if (fp) q_fp.push_back({exp_we, data}); else q_rr.push_back({exp_we, data});
    repeat (ack_dly) @(posedge clk);
    #1;
    chk("addr_hold", 64'(fp ? f_addr : r_addr), 64'(exp_addr));
    ack = 1'b1;
    if (rdy_dly == 0) begin
      rdy  = 1'b1;
      dout = data;
    end
    @(posedge clk); #1;
    ack = 1'b0;
    rdy = 1'b0;
    if (rdy_dly > 0) begin
      repeat (rdy_dly - 1) @(posedge clk);
      #1; rdy = 1'b1; dout = data;
      @(posedge clk); #1; rdy = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_rr = '0; req_fp = '0; ack = 1'b0; rdy = 1'b0; dout = '0;
    slot_addr = {22'h30003, 22'h20002, 22'h01234, 22'h10001};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we",   64'(r_we),   64'd0);
    chk("rst_din",  64'(r_din),  64'd0);
    chk("rst_ok",   64'(r_ok),   64'd0);
    chk("rst_req",  64'(r_req),  64'd0);
    chk("rst_addr", 64'(r_addr), 64'd0);
    chk("rst_busy", 64'(r_busy), 64'd0);
    #1 rst = 1'b0;

    // 1: single request from slot 1
    @(posedge clk); #1 req_rr = 4'b0010;
    serve(0, 2, 3, 32'hDEADBEEF, 22'h01234, 4'b0010, 1);
    repeat (3) @(negedge clk);
    chk("t1_busy", 64'(r_busy), 64'd0);

    // 2: all slots requesting, round robin from pointer 0
    do_reset();
    req_rr = 4'b1111;
    serve(0, 1, 1, 32'h00001000, 22'h10001, 4'b0001, 0);
    serve(0, 1, 2, 32'h00001001, 22'h01234, 4'b0010, 0);
    serve(0, 2, 1, 32'h00001002, 22'h20002, 4'b0100, 0);
    serve(0, 1, 1, 32'h00001003, 22'h30003, 4'b1000, 0);
    serve(0, 1, 1, 32'h00001004, 22'h10001, 4'b0001, 1);
    repeat (4) @(negedge clk);

    // 3: fixed priority, slots 2 and 3 requesting; 2 always wins
    req_fp = 4'b1100;
    serve(1, 1, 2, 32'hA0000000, 22'h20002, 4'b0100, 0);
    serve(1, 1, 1, 32'hA0000001, 22'h20002, 4'b0100, 0);
    serve(1, 2, 1, 32'hA0000002, 22'h20002, 4'b0100, 1);
    repeat (4) @(negedge clk);

    // 4: ack and rdy in the same cycle
    req_rr = 4'b0001;
    serve(0, 1, 0, 32'h5A5A1234, 22'h10001, 4'b0001, 1);
    @(negedge clk);
    chk("t4_din_ok", 64'(r_ok),   64'd1);
    chk("t4_busy",   64'(r_busy), 64'd0);
    chk("t4_req",    64'(r_req),  64'd0);
    repeat (3) @(negedge clk);

    // 5: slot 1 drops req and changes address after grant
    do_reset();
    req_rr = 4'b0010;
    fork
      serve(0, 3, 2, 32'hCAFEF00D, 22'h01234, 4'b0010, 1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          if (r_req) seen = 1'b1;
        end
        #1 slot_addr[43:22] = 22'h3ABCD;
      end
    join
    repeat (3) @(negedge clk);
    slot_addr[43:22] = 22'h01234;

    // 6: reset while waiting for rdy
    req_rr = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (r_req) seen = 1'b1;
    end
    chk("t6_grant", 64'(seen), 64'd1);
    req_rr = '0;
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    chk("t6_busy_wait", 64'(r_busy), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_we",   64'(r_we),   64'd0);
    chk("t6_din",  64'(r_din),  64'd0);
    chk("t6_ok",   64'(r_ok),   64'd0);
    chk("t6_req",  64'(r_req),  64'd0);
    chk("t6_addr", 64'(r_addr), 64'd0);
    chk("t6_busy", 64'(r_busy), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    rdy = 1'b1; dout = 32'hBAD0BAD0;
    @(posedge clk); #1 rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle", 64'(r_busy), 64'd0);
    req_rr = 4'b0100;
    serve(0, 1, 1, 32'h600D600D, 22'h20002, 4'b0100, 1);
    repeat (5) @(negedge clk);

    chk("rr_queue_empty", 64'(q_rr.size()), 64'd0);
    chk("fp_queue_empty", 64'(q_fp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
